mem_arbiter: RTL and testbench

- Owns the byte-serial external RAM/IO port and schedules it between two requesters: instruction-cache refill (ifetch side, 4-byte reads) and the load/store buffer (1/2/4-byte loads and stores).
- Serializes each transaction into byte beats, assembles and sign-extends load data, and returns one completion pulse per transaction.
- Handles IO back-pressure, branch-mispredict flush and the global ready stall.

---
 rtl/mem_arbiter_if.sv | 34 +++
 rtl/mem_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester-side bundle for the icache refill and load/store buffer ports
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH   = 32,
  parameter int LSB_ID_WIDTH = 4
);
  logic                    if_req;
  logic [ADDR_WIDTH-1:0]   if_addr;
  logic                    if_done;
  logic [31:0]             if_data;

  logic                    lsb_req;
  logic                    lsb_we;
  logic [ADDR_WIDTH-1:0]   lsb_addr;
  logic [31:0]             lsb_wdata;
  logic [2:0]              lsb_funct3;
  logic [LSB_ID_WIDTH-1:0] lsb_id;
  logic                    lsb_done;
  logic [31:0]             lsb_rdata;
  logic [LSB_ID_WIDTH-1:0] lsb_done_id;

  modport master (
    output if_req, if_addr,
    output lsb_req, lsb_we, lsb_addr, lsb_wdata, lsb_funct3, lsb_id,
    input  if_done, if_data,
    input  lsb_done, lsb_rdata, lsb_done_id
  );

  modport slave (
    input  if_req, if_addr,
    input  lsb_req, lsb_we, lsb_addr, lsb_wdata, lsb_funct3, lsb_id,
    output if_done, if_data,
    output lsb_done, lsb_rdata, lsb_done_id
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin scheduler of the byte-serial RAM/IO port between icache refill and LSB
module mem_arbiter #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    LSB_ID_WIDTH = 4,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE      = 32'h30000
) (
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  flush,
  input  logic                  io_buffer_full,
  input  logic [7:0]            mem_din,
  output logic                  mem_rw,
  output logic [ADDR_WIDTH-1:0] mem_aout,
  output logic [7:0]            mem_dout,
  output logic                  busy,
  mem_arbiter_if.slave          req_bus
);

  typedef enum logic [2:0] {IDLE, IF_RD, LS_RD, LS_WR, IO_WAIT} state_t;

  state_t                  state, state_n;
  logic [2:0]              cnt, cnt_inc, n_beats;
  logic [ADDR_WIDTH-1:0]   base;
  logic [31:0]             wdata, rbuf, rword;
  logic [2:0]              funct3;
  logic [LSB_ID_WIDTH-1:0] id;
  logic                    last_lsb;
  logic                    if_ok, lsb_ok, grant_if, grant_lsb, finish, io_block;

  function automatic logic [2:0] beats_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] w);
    case (f3)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'b0, w[7:0]};
      3'b101:  return {16'b0, w[15:0]};
      default: return w;
    endcase
  endfunction

  assign cnt_inc  = cnt + 3'd1;
  assign io_block = (mem_aout >= IO_BASE) && io_buffer_full;
  assign mem_rw   = rdy_in && (state == LS_WR) && !io_block;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_in) state <= IDLE;
    else if (rdy_in) state <= state_n;
  end

  always_comb begin
    state_n   = state;
    grant_if  = 1'b0;
    grant_lsb = 1'b0;
    finish    = 1'b0;
    if_ok     = req_bus.if_req && !req_bus.if_done;
    lsb_ok    = req_bus.lsb_req && !req_bus.lsb_done;
    case (state)
      IDLE: begin
        if (!flush) begin
          if (if_ok && lsb_ok) begin
            grant_lsb = !last_lsb;
            grant_if  = last_lsb;
          end else begin
            grant_if  = if_ok;
            grant_lsb = lsb_ok;
          end
          if (grant_if) state_n = IF_RD;
          else if (grant_lsb) state_n = req_bus.lsb_we ? LS_WR : LS_RD;
        end
      end
      IF_RD, LS_RD: begin
        // Reads need one extra cycle after the last address for the byte to come back.
        if (flush) state_n = IDLE;
        else if (cnt == n_beats) begin
          finish  = 1'b1;
          state_n = IDLE;
        end
      end
      LS_WR: begin
        if (io_block) state_n = IO_WAIT;
        else if (cnt == n_beats - 3'd1) begin
          finish  = 1'b1;
          state_n = IDLE;
        end
      end
      IO_WAIT: if (!io_buffer_full) state_n = LS_WR;
      default: state_n = IDLE;
    endcase
  end

  // Merge the byte arriving this cycle so the final beat can complete without an extra cycle.
  always_comb begin
    rword = rbuf;
    case (cnt)
      3'd1:    rword[7:0]   = mem_din;
      3'd2:    rword[15:8]  = mem_din;
      3'd3:    rword[23:16] = mem_din;
      3'd4:    rword[31:24] = mem_din;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_in) begin
      mem_aout            <= '0;
      mem_dout            <= '0;
      cnt                 <= '0;
      n_beats             <= '0;
      base                <= '0;
      wdata               <= '0;
      rbuf                <= '0;
      funct3              <= '0;
      id                  <= '0;
      last_lsb            <= 1'b0;
      req_bus.if_done     <= 1'b0;
      req_bus.if_data     <= '0;
      req_bus.lsb_done    <= 1'b0;
      req_bus.lsb_rdata   <= '0;
      req_bus.lsb_done_id <= '0;
    end else if (rdy_in) begin
      req_bus.if_done  <= 1'b0;
      req_bus.lsb_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_if) begin
            cnt      <= '0;
            rbuf     <= '0;
            base     <= req_bus.if_addr;
            mem_aout <= req_bus.if_addr;
            n_beats  <= 3'd4;
            last_lsb <= 1'b0;
          end else if (grant_lsb) begin
            cnt      <= '0;
            rbuf     <= '0;
            base     <= req_bus.lsb_addr;
            mem_aout <= req_bus.lsb_addr;
            mem_dout <= req_bus.lsb_wdata[7:0];
            wdata    <= req_bus.lsb_wdata;
            n_beats  <= beats_of(req_bus.lsb_funct3);
            funct3   <= req_bus.lsb_funct3;
            id       <= req_bus.lsb_id;
            last_lsb <= 1'b1;
          end
        end
        IF_RD, LS_RD: begin
          if (!flush) begin
            rbuf <= rword;
            cnt  <= cnt_inc;
            if (cnt_inc < n_beats) mem_aout <= base + ADDR_WIDTH'(cnt_inc);
            if (finish) begin
              if (state == IF_RD) begin
                req_bus.if_done <= 1'b1;
                req_bus.if_data <= rword;
              end else begin
                req_bus.lsb_done    <= 1'b1;
                req_bus.lsb_rdata   <= extend(funct3, rword);
                req_bus.lsb_done_id <= id;
              end
            end
          end
        end
        LS_WR: begin
          if (!io_block) begin
            cnt <= cnt_inc;
            if (finish) begin
              req_bus.lsb_done    <= 1'b1;
              req_bus.lsb_done_id <= id;
            end else begin
              mem_aout <= base + ADDR_WIDTH'(cnt_inc);
              mem_dout <= wdata[{cnt_inc[1:0], 3'b000} +: 8];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed-vector bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        flush = 1'b0;
  logic        io_buffer_full = 1'b0;
  logic [7:0]  mem_din;
  logic        mem_rw;
  logic [31:0] mem_aout;
  logic [7:0]  mem_dout;
  logic        busy;

  mem_arbiter_if #(.ADDR_WIDTH(32), .LSB_ID_WIDTH(4)) bus ();

  mem_arbiter #(.ADDR_WIDTH(32), .LSB_ID_WIDTH(4), .IO_BASE(32'h30000)) dut (
    .clk            (clk),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .flush          (flush),
    .io_buffer_full (io_buffer_full),
    .mem_din        (mem_din),
    .mem_rw         (mem_rw),
    .mem_aout       (mem_aout),
    .mem_dout       (mem_dout),
    .busy           (busy),
    .req_bus        (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]  ram [0:4095];
  logic [31:0] wr_addr_q [$];
  logic [7:0]  wr_data_q [$];
  int          n_cmp = 0;
  int          n_err = 0;

  always @(posedge clk) begin
    mem_din <= ram[mem_aout[11:0]];
    if (rst_in && mem_rw) begin
      if (mem_aout < 32'h30000) ram[mem_aout[11:0]] <= mem_dout;
      wr_addr_q.push_back(mem_aout);
      wr_data_q.push_back(mem_dout);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_in = 1'b0;
    bus.if_req = 1'b0;
    bus.lsb_req = 1'b0;
    flush = 1'b0;
    io_buffer_full = 1'b0;
    rdy_in = 1'b1;
    repeat (2) @(negedge clk);
    rst_in = 1'b1;
  endtask

  task automatic wait_lsb(input int budget, output int lat);
    lat = -1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (bus.lsb_done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic wait_if(input int budget, output int lat);
    lat = -1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (bus.if_done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [2:0] f3, input logic [3:0] tag_id,
                         output logic [31:0] data, output int lat, output logic [3:0] did);
    bus.lsb_we = 1'b0;
    bus.lsb_addr = addr;
    bus.lsb_funct3 = f3;
    bus.lsb_id = tag_id;
    bus.lsb_wdata = '0;
    bus.lsb_req = 1'b1;
    wait_lsb(20, lat);
    data = bus.lsb_rdata;
    did = bus.lsb_done_id;
    bus.lsb_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] w;
    logic [3:0]  did;
    int          lat;
    int          cnt_hi;

    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'h00; ram[12'h103] = 8'h00;
    ram[12'h200] = 8'h80; ram[12'h201] = 8'h00; ram[12'h202] = 8'h01; ram[12'h203] = 8'h80;
    bus.if_addr = '0; bus.lsb_we = 1'b0; bus.lsb_addr = '0; bus.lsb_wdata = '0;
    bus.lsb_funct3 = '0; bus.lsb_id = '0;

    do_reset();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rw", mem_rw, 0);
    check_eq("rst_aout", mem_aout, 0);
    check_eq("rst_dout", mem_dout, 0);
    check_eq("rst_if_done", bus.if_done, 0);
    check_eq("rst_lsb_done", bus.lsb_done, 0);
    check_eq("rst_if_data", bus.if_data, 0);
    check_eq("rst_lsb_rdata", bus.lsb_rdata, 0);
    check_eq("rst_done_id", bus.lsb_done_id, 0);

    // IF-only read
    bus.if_addr = 32'h100;
    bus.if_req = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k <= 4) begin
        check_eq($sformatf("if_aout_%0d", k), mem_aout, 32'h100 + k - 1);
        check_eq($sformatf("if_rw_%0d", k), mem_rw, 0);
      end
      if (k == 5) check_eq("if_done_early", bus.if_done, 0);
    end
    check_eq("if_done", bus.if_done, 1);
    check_eq("if_data", bus.if_data, 32'h0000_0513);
    check_eq("if_idle", busy, 0);
    bus.if_req = 1'b0;
    @(negedge clk);

    // Load extension vectors
    do_load(32'h200, 3'b000, 4'h5, d, lat, did);
    check_eq("lb_data", d, 32'hFFFF_FF80);
    check_eq("lb_lat", lat, 3);
    check_eq("lb_id", did, 4'h5);
    do_load(32'h200, 3'b100, 4'h9, d, lat, did);
    check_eq("lbu_data", d, 32'h0000_0080);
    check_eq("lbu_id", did, 4'h9);
    do_load(32'h202, 3'b001, 4'h2, d, lat, did);
    check_eq("lh_data", d, 32'hFFFF_8001);
    check_eq("lh_lat", lat, 4);
    do_load(32'h202, 3'b101, 4'h2, d, lat, did);
    check_eq("lhu_data", d, 32'h0000_8001);
    do_load(32'h200, 3'b010, 4'hC, d, lat, did);
    check_eq("lw_data", d, 32'h8001_0080);
    check_eq("lw_lat", lat, 6);

    // Reset mid-transaction aborts with no done
    bus.if_addr = 32'h100;
    bus.if_req = 1'b1;
    repeat (2) @(negedge clk);
    rst_in = 1'b0;
    bus.if_req = 1'b0;
    cnt_hi = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.if_done) cnt_hi++;
    end
    check_eq("rstmid_done", cnt_hi, 0);
    check_eq("rstmid_busy", busy, 0);
    check_eq("rstmid_aout", mem_aout, 0);
    rst_in = 1'b1;

    // Simultaneous requests: LSB wins the first tie after reset
    @(negedge clk);
    w = 32'h1122_3344;
    bus.lsb_we = 1'b1; bus.lsb_addr = 32'h400; bus.lsb_wdata = w;
    bus.lsb_funct3 = 3'b010; bus.lsb_id = 4'h3;
    bus.if_addr = 32'h100;
    bus.lsb_req = 1'b1;
    bus.if_req = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check_eq($sformatf("rr_st_aout_%0d", k), mem_aout, 32'h400 + k - 1);
      check_eq($sformatf("rr_st_rw_%0d", k), mem_rw, 1);
      check_eq($sformatf("rr_st_dout_%0d", k), mem_dout, w[8*(k-1) +: 8]);
    end
    @(negedge clk);
    check_eq("rr_st_done", bus.lsb_done, 1);
    check_eq("rr_if_not_done", bus.if_done, 0);
    bus.lsb_req = 1'b0;
    @(negedge clk);
    check_eq("rr_if_aout", mem_aout, 32'h100);
    check_eq("rr_if_busy", busy, 1);
    wait_if(10, lat);
    check_eq("rr_if_lat", lat, 5);
    check_eq("rr_if_data", bus.if_data, 32'h0000_0513);
    bus.if_req = 1'b0;
    @(negedge clk);
    check_eq("rr_ram_word", {ram[12'h403], ram[12'h402], ram[12'h401], ram[12'h400]}, w);

    // Second tie: IF was granted last, so LSB goes first
    bus.lsb_we = 1'b0; bus.lsb_addr = 32'h200; bus.lsb_funct3 = 3'b010; bus.lsb_id = 4'h7;
    bus.lsb_req = 1'b1;
    bus.if_req = 1'b1;
    @(negedge clk);
    check_eq("rr2_lsb_first", mem_aout, 32'h200);
    wait_lsb(10, lat);
    check_eq("rr2_lsb_lat", lat, 5);
    check_eq("rr2_lsb_data", bus.lsb_rdata, 32'h8001_0080);
    check_eq("rr2_lsb_id", bus.lsb_done_id, 4'h7);
    bus.lsb_req = 1'b0;
    wait_if(10, lat);
    check_eq("rr2_if_lat", lat, 6);
    bus.if_req = 1'b0;
    @(negedge clk);

    // IO back-pressure
    wr_addr_q.delete();
    wr_data_q.delete();
    io_buffer_full = 1'b1;
    bus.lsb_we = 1'b1; bus.lsb_addr = 32'h30000; bus.lsb_wdata = 32'h0000_0041;
    bus.lsb_funct3 = 3'b000; bus.lsb_id = 4'h1;
    bus.lsb_req = 1'b1;
    cnt_hi = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (mem_rw) cnt_hi++;
    end
    check_eq("io_rw_held", cnt_hi, 0);
    check_eq("io_busy", busy, 1);
    io_buffer_full = 1'b0;
    @(negedge clk);
    check_eq("io_beat_rw", mem_rw, 1);
    check_eq("io_beat_aout", mem_aout, 32'h30000);
    check_eq("io_beat_dout", mem_dout, 8'h41);
    @(negedge clk);
    check_eq("io_done", bus.lsb_done, 1);
    bus.lsb_req = 1'b0;
    @(negedge clk);
    check_eq("io_wr_count", wr_addr_q.size(), 1);
    if (wr_addr_q.size() == 1) begin
      check_eq("io_wr_addr", wr_addr_q[0], 32'h30000);
      check_eq("io_wr_data", wr_data_q[0], 8'h41);
    end

    // Flush during IF_RD beat 2
    bus.if_addr = 32'h100;
    bus.if_req = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("fl_beat2_aout", mem_aout, 32'h102);
    flush = 1'b1;
    bus.if_req = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    check_eq("fl_idle", busy, 0);
    check_eq("fl_rw", mem_rw, 0);
    cnt_hi = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.if_done) cnt_hi++;
      @(negedge clk);
    end
    check_eq("fl_no_done", cnt_hi, 0);

    // rdy_in stall mid-store
    wr_addr_q.delete();
    wr_data_q.delete();
    w = 32'hA1B2_C3D4;
    bus.lsb_we = 1'b1; bus.lsb_addr = 32'h600; bus.lsb_wdata = w;
    bus.lsb_funct3 = 3'b010; bus.lsb_id = 4'h4;
    bus.lsb_req = 1'b1;
    repeat (2) @(negedge clk);
    rdy_in = 1'b0;
    cnt_hi = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (mem_rw) cnt_hi++;
    end
    check_eq("st_stall_rw", cnt_hi, 0);
    rdy_in = 1'b1;
    wait_lsb(20, lat);
    check_eq("st_done_seen", lat > 0, 1);
    bus.lsb_req = 1'b0;
    @(negedge clk);
    check_eq("st_wr_count", wr_addr_q.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < wr_addr_q.size()) begin
        check_eq($sformatf("st_wr_addr_%0d", k), wr_addr_q[k], 32'h600 + k);
        check_eq($sformatf("st_wr_data_%0d", k), wr_data_q[k], w[8*k +: 8]);
      end
    end
    check_eq("st_ram_word", {ram[12'h603], ram[12'h602], ram[12'h601], ram[12'h600]}, w);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
